// File: rtl/keypad_matrix_model_pkg.sv
// Shared keypad constants, FSM state type and key-to-matrix mapping.
// Imported by the keypad responder and reusable by the scanner side.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR        = 4'd10;
    localparam logic [3:0] KEY_HASH        = 4'd11;
    localparam logic [3:0] KEY_INVALID_MIN = 4'd12;

    typedef enum logic [2:0] {
        KP_IDLE       = 3'd0,
        KP_BOUNCE_IN  = 3'd1,
        KP_HOLD       = 3'd2,
        KP_BOUNCE_OUT = 3'd3,
        KP_GAP        = 3'd4
    } kp_state;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } kp_rowcol_t;

    // Physical layout: rows 1-2-3 / 4-5-6 / 7-8-9 / *-0-#.
    function automatic kp_rowcol_t key_to_rowcol(input logic [3:0] code);
        kp_rowcol_t rc;
        rc.row = 2'd3;
        rc.col = 2'd1;
        case (code)
            4'd1:     begin rc.row = 2'd0; rc.col = 2'd0; end
            4'd2:     begin rc.row = 2'd0; rc.col = 2'd1; end
            4'd3:     begin rc.row = 2'd0; rc.col = 2'd2; end
            4'd4:     begin rc.row = 2'd1; rc.col = 2'd0; end
            4'd5:     begin rc.row = 2'd1; rc.col = 2'd1; end
            4'd6:     begin rc.row = 2'd1; rc.col = 2'd2; end
            4'd7:     begin rc.row = 2'd2; rc.col = 2'd0; end
            4'd8:     begin rc.row = 2'd2; rc.col = 2'd1; end
            4'd9:     begin rc.row = 2'd2; rc.col = 2'd2; end
            KEY_STAR: begin rc.row = 2'd3; rc.col = 2'd0; end
            KEY_HASH: begin rc.row = 2'd3; rc.col = 2'd2; end
            default:  begin rc.row = 2'd3; rc.col = 2'd1; end
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/keypad_matrix_model_bounce_gen.sv
// Toggle generator for one bounce phase: loads a start level, then inverts
// it every TOGGLE cycles while the phase is running.
module keypad_matrix_model_bounce_gen #(
    parameter int TOGGLE = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_init,
    input  logic i_run,
    output logic o_level
);

    localparam int TW = $clog2(TOGGLE) + 1;
    localparam logic [TW-1:0] TOGGLE_RELOAD = TW'(TOGGLE - 1);

    logic [TW-1:0] r_tcnt;
    logic          r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tcnt  <= '0;
            r_level <= 1'b0;
        end else if (i_load) begin
            r_tcnt  <= TOGGLE_RELOAD;
            r_level <= i_init;
        end else if (i_run) begin
            if (r_tcnt == '0) begin
                r_tcnt  <= TOGGLE_RELOAD;
                r_level <= ~r_level;
            end else begin
                r_tcnt <= r_tcnt - 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/keypad_matrix_model.sv
// Passive 3x4 keypad responder: emulates a bounced key press on request and
// answers the scanner's active-low row drive on the active-low column senses.
module keypad_matrix_model
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 32,
    parameter int BOUNCE_TOGGLE = 4,
    parameter int HOLD_CYCLES   = 2000,
    parameter int GAP_CYCLES    = 500
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    input  logic [3:0] key_code,
    input  logic       press_req,
    output logic       busy,
    output logic       press_done,
    output logic       press_err,
    output logic       contact
);

    localparam int MAX_AB = (BOUNCE_CYCLES > BOUNCE_TOGGLE) ? BOUNCE_CYCLES : BOUNCE_TOGGLE;
    localparam int MAX_CD = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] LD_BOUNCE = CW'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LD_GAP    = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);
    localparam bit HAS_GAP    = (GAP_CYCLES > 0);

    kp_state       r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_row;
    logic [1:0]    r_col;
    logic          r_done;
    logic          r_err;

    kp_state       w_next;
    logic [CW-1:0] w_load;
    logic          w_accept;
    logic          w_err;
    logic          w_enter;
    logic          w_in_bounce;
    logic          w_bounce_level;
    logic          w_row_driven;
    logic [3:0]    w_rows_n;
    kp_rowcol_t    w_rc;

    assign w_rc = key_to_rowcol(key_code);

    // Zero-length phases are skipped so each phase lasts exactly its parameter.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_err    = 1'b0;
        case (r_state)
            KP_IDLE: begin
                if (press_req) begin
                    if (key_code >= KEY_INVALID_MIN) begin
                        w_err = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = HAS_BOUNCE ? KP_BOUNCE_IN : KP_HOLD;
                    end
                end
            end
            KP_BOUNCE_IN: if (r_cnt == '0) w_next = KP_HOLD;
            KP_HOLD: begin
                if (r_cnt == '0)
                    w_next = HAS_BOUNCE ? KP_BOUNCE_OUT : (HAS_GAP ? KP_GAP : KP_IDLE);
            end
            KP_BOUNCE_OUT: if (r_cnt == '0) w_next = HAS_GAP ? KP_GAP : KP_IDLE;
            KP_GAP:        if (r_cnt == '0) w_next = KP_IDLE;
            default:       w_next = KP_IDLE;
        endcase
    end

    always_comb begin
        w_load = '0;
        case (w_next)
            KP_BOUNCE_IN, KP_BOUNCE_OUT: w_load = LD_BOUNCE;
            KP_HOLD:                     w_load = LD_HOLD;
            KP_GAP:                      w_load = LD_GAP;
            default:                     w_load = '0;
        endcase
    end

    assign w_enter = (w_next != r_state);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= KP_IDLE;
            r_cnt   <= '0;
            r_row   <= 2'd0;
            r_col   <= 2'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_enter && (w_next == KP_IDLE);
            r_err   <= w_err;
            if (w_enter)
                r_cnt <= w_load;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (w_accept) begin
                r_row <= w_rc.row;
                r_col <= w_rc.col;
            end
        end
    end

    assign w_in_bounce = (r_state == KP_BOUNCE_IN) || (r_state == KP_BOUNCE_OUT);

    keypad_matrix_model_bounce_gen #(
        .TOGGLE (BOUNCE_TOGGLE)
    ) u_bounce_gen (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_load  (w_enter && ((w_next == KP_BOUNCE_IN) || (w_next == KP_BOUNCE_OUT))),
        .i_init  (w_next == KP_BOUNCE_IN),
        .i_run   (w_in_bounce),
        .o_level (w_bounce_level)
    );

    assign contact = w_in_bounce ? w_bounce_level : (r_state == KP_HOLD);

    // Only the latched row is examined, so other rows driven low never alias.
    assign w_rows_n     = {D, C, B, A};
    assign w_row_driven = ~w_rows_n[r_row];

    assign E = ~(contact && w_row_driven && (r_col == 2'd0));
    assign F = ~(contact && w_row_driven && (r_col == 2'd1));
    assign G = ~(contact && w_row_driven && (r_col == 2'd2));

    assign busy       = (r_state != KP_IDLE);
    assign press_done = r_done;
    assign press_err  = r_err;

endmodule

// File: doc/keypad_matrix_model.md
Name: keypad_matrix_model

Overview:
- Synthesizable 3x4 matrix-keypad responder: the passive-keypad end of the row-drive / column-sense scan interface used by the keypad scanner.
- A control port requests a press of one key. The block then emulates contact bounce, a hold, release bounce and a mandatory gap.
- Columns respond to the scanner's row drive exactly as a physical keypad would. This lets the scanner, tone and display chain run closed-loop on board or in simulation without a real keypad.

Parameters:
- BOUNCE_CYCLES, 32, length of each bounce phase (press and release), in sys_clk cycles; >= 0.
- BOUNCE_TOGGLE, 4, cycles between contact toggles during bounce; >= 1.
- HOLD_CYCLES, 2000, stable-contact duration; >= 1.
- GAP_CYCLES, 500, forced open-contact time after release before the next request is accepted; >= 0.

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous active-low reset
- A  input  1  row 0 drive from scanner, active-low (keys 1 2 3)
- B  input  1  row 1 drive, active-low (keys 4 5 6)
- C  input  1  row 2 drive, active-low (keys 7 8 9)
- D  input  1  row 3 drive, active-low (keys * 0 #)
- E  output  1  column 0 sense, active-low (keys 1 4 7 *)
- F  output  1  column 1 sense, active-low (keys 2 5 8 0)
- G  output  1  column 2 sense, active-low (keys 3 6 9 #)
- key_code  input  4  key to press: 0-9 digits, 10 = *, 11 = #
- press_req  input  1  single-cycle request strobe
- busy  output  1  high from acceptance until the end of GAP
- press_done  output  1  one-cycle pulse on the GAP -> IDLE transition
- press_err  output  1  one-cycle pulse when press_req arrives in IDLE with key_code >= 12
- contact  output  1  current emulated switch-contact state (debug)

Behaviour:
- One clock (sys_clk), asynchronous active-low reset (sys_rst_n).
- Reset values: state IDLE, contact 0, busy 0, press_done 0, press_err 0, counters 0, latched key 0. E, F and G are therefore 1 (open).
- Column outputs are combinational from the registered contact and latched row/col and the live A-D inputs, with zero latency:
  - col_n = 0 iff contact = 1, and the latched row's input is 0, and n = latched col.
  - All other columns = 1.
  - Multiple rows low simultaneously: only the latched row matters.
- Key map (row, col):
  - 1 = (0,0), 2 = (0,1), 3 = (0,2)
  - 4 = (1,0), 5 = (1,1), 6 = (1,2)
  - 7 = (2,0), 8 = (2,1), 9 = (2,2)
  - * = (3,0), 0 = (3,1), # = (3,2)
- State machine IDLE -> BOUNCE_IN -> HOLD -> BOUNCE_OUT -> GAP -> IDLE:
  - IDLE: if press_req and key_code <= 11, latch row/col and go to BOUNCE_IN. busy is 1 from the next cycle.
  - IDLE, invalid key: if press_req and key_code >= 12, pulse press_err next cycle and stay in IDLE.
  - BOUNCE_IN: contact starts at 1 and inverts every BOUNCE_TOGGLE cycles. After BOUNCE_CYCLES cycles go to HOLD. If BOUNCE_CYCLES = 0, go straight to HOLD.
  - HOLD: contact = 1 for exactly HOLD_CYCLES cycles, then BOUNCE_OUT.
  - BOUNCE_OUT: contact starts at 0, same toggle rule as BOUNCE_IN, BOUNCE_CYCLES cycles long. Contact is forced to 0 on exit.
  - GAP: contact = 0 for GAP_CYCLES cycles. On exit, pulse press_done, drop busy and return to IDLE.
- press_req while busy: ignored, no error, no queueing.
- press_req on the same cycle the block returns to IDLE: ignored. It is accepted only when state is IDLE at the sampling edge.
- Reset mid-operation: contact goes to 0 immediately (columns open asynchronously via the register reset). No press_done pulse.
- Counters: one phase counter sized clog2 of the largest of the four parameters, plus 1 bit. It is reloaded on every state entry. There is no wrap-around within a phase.

Decomposition:
- Shared package keypad_pkg holds:
  - key-code constants (KEY_STAR = 10, KEY_HASH = 11, KEY_INVALID_MIN = 12);
  - the kp_state enum;
  - a function key_to_rowcol(code) returning the 2-bit row and 2-bit col.
- The scanner can reuse the same constants.
- One natural sub-module: bounce_gen, a toggle counter producing the bouncing contact level for a phase.

Test Plan:
- Reset, then press key 5 with BOUNCE_CYCLES = 0, HOLD_CYCLES = 10, GAP_CYCLES = 3, rows held B = 0, others 1. Required: F = 0 for exactly 10 cycles; E = G = 1 throughout; press_done pulses once, 3 cycles after release; busy then falls.
- Press # (11) with only A driven low. Required: E = F = G = 1 throughout. Then drive D = 0 during HOLD: G = 0 in the same cycle.
- Defaults, press key 1 with A = 0. Required: E toggles every 4 cycles for 32 cycles, is stable 0 for 2000 cycles, then bounces 32 cycles; no press_done until the 500-cycle gap ends.
- press_req with key_code = 13. Required: press_err is a 1-cycle pulse, busy stays 0, columns stay 1. A second press_req mid-HOLD is ignored.
- Assert sys_rst_n = 0 during HOLD of key 0 with C = D = 0. Required: F returns to 1 immediately; no press_done; a new request after reset is accepted.
- Closed loop with the keypad scanner: press 1 through 9, * , 0, # in sequence. Required: the scanner's locked key output matches each code after debounce.
